// File: rtl/register_bank_mp_pkg.sv
// Shared types and defaults for the multi-port register bank.
// Op codes for the in-place op port live here so cell and top agree on encoding.
package register_bank_mp_pkg;

   localparam int DATA_WIDTH_DFLT = 8;
   localparam int NUM_REG_DFLT    = 8;

   typedef enum logic [1:0] {
      OP_NOP = 2'b00,
      OP_INC = 2'b01,
      OP_DEC = 2'b10,
      OP_CLR = 2'b11
   } op_mode_e;

   // INC and DEC are the only ops that produce a carry/borrow result.
   function automatic logic is_step(input op_mode_e m);
      return (m == OP_INC) || (m == OP_DEC);
   endfunction

endpackage

// File: rtl/register_bank_mp_cell.sv
// One register of the bank: bus load has priority over the in-place op; write protect blocks both.
// Reports next-state zero and wrap so the top can register flags aligned with the contents.
module register_bank_mp_cell
   import register_bank_mp_pkg::*;
#(
   parameter int DATA_WIDTH = DATA_WIDTH_DFLT
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  ld,
   input  logic [DATA_WIDTH-1:0] ld_data,
   input  logic                  op,
   input  op_mode_e              op_mode,
   input  logic                  ro,
   output logic [DATA_WIDTH-1:0] q,
   output logic                  nxt_zero,
   output logic                  wrap
);

   localparam logic [DATA_WIDTH-1:0] ONE = {{(DATA_WIDTH-1){1'b0}}, 1'b1};

   logic [DATA_WIDTH-1:0] q_q;
   logic [DATA_WIDTH-1:0] q_d;

   always_comb begin
      q_d  = q_q;
      wrap = 1'b0;
      if (!ro) begin
         if (ld) begin
            q_d = ld_data;
         end else if (op) begin
            case (op_mode)
               OP_INC: begin
                  q_d  = q_q + ONE;
                  wrap = &q_q;
               end
               OP_DEC: begin
                  q_d  = q_q - ONE;
                  wrap = ~|q_q;
               end
               OP_CLR:  q_d = '0;
               default: q_d = q_q;
            endcase
         end
      end
      // Reset discards any in-flight load or op.
      if (!reset) begin
         q_d = '0;
      end
   end

   always_ff @(posedge clk) begin
      q_q <= q_d;
   end

   assign q        = q_q;
   assign nxt_zero = ~|q_d;

endmodule

// File: rtl/register_bank_mp.sv
// General register file: tri-state bus port, two combinational ALU read ports, one INC/DEC/CLR op port.
// Bus write beats an op to the same register (op dropped, op_conflict pulses); protected registers ignore both.
module register_bank_mp
   import register_bank_mp_pkg::*;
#(
   parameter int                   DATA_WIDTH = DATA_WIDTH_DFLT,
   parameter int                   NUM_REG    = NUM_REG_DFLT,
   parameter int                   ADDR_W     = $clog2(NUM_REG),
   parameter logic [NUM_REG-1:0]   RO_MASK    = '0
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  CS,
   input  logic                  RD_WR,
   input  logic [ADDR_W-1:0]     address,
   inout  wire  [DATA_WIDTH-1:0] data,
   input  logic [ADDR_W-1:0]     ra_addr,
   output logic [DATA_WIDTH-1:0] ra_data,
   input  logic [ADDR_W-1:0]     rb_addr,
   output logic [DATA_WIDTH-1:0] rb_data,
   input  logic                  op_en,
   input  logic [1:0]            op_mode,
   input  logic [ADDR_W-1:0]     op_addr,
   output logic [NUM_REG-1:0]    zero_flags,
   output logic                  carry,
   output logic                  op_conflict
);

   logic                  bus_wr;
   logic                  bus_rd;
   logic                  op_ro;
   logic                  collide;
   logic                  op_exec;
   op_mode_e              op_mode_t;

   logic [DATA_WIDTH-1:0] q_arr [NUM_REG];
   logic [NUM_REG-1:0]    nxt_zero_vec;
   logic [NUM_REG-1:0]    wrap_vec;

   logic [NUM_REG-1:0]    zero_flags_q, zero_flags_d;
   logic                  carry_q, carry_d;
   logic                  op_conflict_q, op_conflict_d;

   assign bus_wr    = CS & ~RD_WR;
   assign bus_rd    = CS &  RD_WR;
   assign op_mode_t = op_mode_e'(op_mode);
   assign op_ro     = RO_MASK[op_addr];

   // A protected target silently swallows the op, so it never counts as a collision.
   assign collide = bus_wr & op_en & (address == op_addr) & ~op_ro;
   assign op_exec = op_en & ~op_ro & ~collide;

   for (genvar i = 0; i < NUM_REG; i++) begin : g_cell
      localparam logic [ADDR_W-1:0] IDX = ADDR_W'(i);

      logic ld_sel;
      logic op_sel;

      assign ld_sel = bus_wr  & (address == IDX);
      assign op_sel = op_exec & (op_addr == IDX);

      register_bank_mp_cell #(
         .DATA_WIDTH (DATA_WIDTH)
      ) u_cell (
         .clk      (clk),
         .reset    (reset),
         .ld       (ld_sel),
         .ld_data  (data),
         .op       (op_sel),
         .op_mode  (op_mode_t),
         .ro       (RO_MASK[i]),
         .q        (q_arr[i]),
         .nxt_zero (nxt_zero_vec[i]),
         .wrap     (wrap_vec[i])
      );
   end

   assign ra_data = q_arr[ra_addr];
   assign rb_data = q_arr[rb_addr];

   // Bus is only ever released by CS/RD_WR; reset does not affect the driver.
   assign data = bus_rd ? q_arr[address] : {DATA_WIDTH{1'bz}};

   always_comb begin
      zero_flags_d  = nxt_zero_vec;
      op_conflict_d = collide;
      carry_d       = carry_q;
      if (op_exec && is_step(op_mode_t)) begin
         carry_d = wrap_vec[op_addr];
      end
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         zero_flags_q  <= '1;
         carry_q       <= 1'b0;
         op_conflict_q <= 1'b0;
      end else begin
         zero_flags_q  <= zero_flags_d;
         carry_q       <= carry_d;
         op_conflict_q <= op_conflict_d;
      end
   end

   assign zero_flags  = zero_flags_q;
   assign carry       = carry_q;
   assign op_conflict = op_conflict_q;

endmodule

// File: tb/tb_register_bank_mp.sv
// Scoreboard bench for register_bank_mp with register 0 write-protected.
module tb_register_bank_mp;

   localparam int DW = 8;
   localparam int NR = 8;
   localparam int AW = 3;
   localparam logic [NR-1:0] RO = 8'h01;

   logic          clk;
   logic          reset;
   logic          CS;
   logic          RD_WR;
   logic [AW-1:0] address;
   wire  [DW-1:0] data;
   logic [DW-1:0] drv;
   logic          oe;
   logic [AW-1:0] ra_addr;
   logic [DW-1:0] ra_data;
   logic [AW-1:0] rb_addr;
   logic [DW-1:0] rb_data;
   logic          op_en;
   logic [1:0]    op_mode;
   logic [AW-1:0] op_addr;
   logic [NR-1:0] zero_flags;
   logic          carry;
   logic          op_conflict;

   int total = 0;
   int bad   = 0;

   logic [DW-1:0] model [NR];
   logic [DW-1:0] exp_q [$];

   assign data = oe ? drv : {DW{1'bz}};

   register_bank_mp #(
      .DATA_WIDTH (DW),
      .NUM_REG    (NR),
      .ADDR_W     (AW),
      .RO_MASK    (RO)
   ) dut (
      .clk         (clk),
      .reset       (reset),
      .CS          (CS),
      .RD_WR       (RD_WR),
      .address     (address),
      .data        (data),
      .ra_addr     (ra_addr),
      .ra_data     (ra_data),
      .rb_addr     (rb_addr),
      .rb_data     (rb_data),
      .op_en       (op_en),
      .op_mode     (op_mode),
      .op_addr     (op_addr),
      .zero_flags  (zero_flags),
      .carry       (carry),
      .op_conflict (op_conflict)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // One clock with optional bus write and optional op driven together.
   task automatic drive_cycle(input logic wr, input logic [AW-1:0] wa, input logic [DW-1:0] wv,
                              input logic oen, input logic [1:0] om, input logic [AW-1:0] oa);
      CS = wr; RD_WR = 1'b0; address = wa; oe = wr; drv = wv;
      op_en = oen; op_mode = om; op_addr = oa;
      tick();
      CS = 1'b0; oe = 1'b0; op_en = 1'b0;
      if (wr && !RO[wa]) model[wa] = wv;
      if (oen && !RO[oa] && !(wr && wa == oa)) begin
         case (om)
            2'b01:   model[oa] = model[oa] + 8'd1;
            2'b10:   model[oa] = model[oa] - 8'd1;
            2'b11:   model[oa] = 8'd0;
            default: model[oa] = model[oa];
         endcase
      end
   endtask

   task automatic test_reset();
      reset = 1'b0; CS = 1'b1; RD_WR = 1'b0; address = 3'd2; oe = 1'b1; drv = 8'hAA;
      op_en = 1'b1; op_mode = 2'b01; op_addr = 3'd1;
      tick(); tick();
      reset = 1'b1; CS = 1'b0; oe = 1'b0; op_en = 1'b0;
      for (int i = 0; i < NR; i++) model[i] = 8'd0;
      for (int i = 0; i < NR; i++) begin
         ra_addr = AW'(i); #1;
         total++;
         if (ra_data !== 8'h00) begin bad++; $display("FAIL reset_reg%0d got=%h exp=00", i, ra_data); end
      end
      total++;
      if (zero_flags !== 8'hFF) begin bad++; $display("FAIL reset_zf got=%h exp=ff", zero_flags); end
      total++;
      if (carry !== 1'b0) begin bad++; $display("FAIL reset_carry got=%b exp=0", carry); end
      total++;
      if (op_conflict !== 1'b0) begin bad++; $display("FAIL reset_conflict got=%b exp=0", op_conflict); end
      // With CS low the DUT must not fight an external driver.
      oe = 1'b1; drv = 8'h3C; #1;
      total++;
      if (data !== 8'h3C) begin bad++; $display("FAIL bus_release got=%h exp=3c", data); end
      oe = 1'b0;
   endtask

   task automatic test_write_read();
      logic [DW-1:0] e;
      logic [NR-1:0] ezf;
      for (int i = 0; i < NR; i++)
         drive_cycle(1'b1, AW'(i), DW'($urandom_range(1, 255)), 1'b0, 2'b00, 3'd0);
      for (int i = 0; i < NR; i++) begin
         CS = 1'b1; RD_WR = 1'b1; address = AW'(i);
         exp_q.push_back(model[i]);
         #3;
         e = exp_q.pop_front();
         total++;
         if (data !== e) begin bad++; $display("FAIL bus_read%0d got=%h exp=%h", i, data, e); end
         tick();
         CS = 1'b0;
      end
      for (int i = 0; i < NR; i++) begin
         ra_addr = AW'(i); rb_addr = AW'(NR - 1 - i);
         exp_q.push_back(model[i]); exp_q.push_back(model[NR - 1 - i]);
         #1;
         e = exp_q.pop_front();
         total++;
         if (ra_data !== e) begin bad++; $display("FAIL ra%0d got=%h exp=%h", i, ra_data, e); end
         e = exp_q.pop_front();
         total++;
         if (rb_data !== e) begin bad++; $display("FAIL rb%0d got=%h exp=%h", NR - 1 - i, rb_data, e); end
      end
      for (int i = 0; i < NR; i++) ezf[i] = (model[i] == 8'd0);
      total++;
      if (zero_flags !== ezf) begin bad++; $display("FAIL wr_zf got=%h exp=%h", zero_flags, ezf); end
   endtask

   task automatic test_inc_dec();
      logic [DW-1:0] ev [3] = '{8'h00, 8'hFF, 8'hFE};
      logic          ec [3] = '{1'b1, 1'b1, 1'b0};
      logic [1:0]    om [3] = '{2'b01, 2'b10, 2'b10};
      drive_cycle(1'b1, 3'd3, 8'hFF, 1'b0, 2'b00, 3'd0);
      rb_addr = 3'd3;
      for (int k = 0; k < 3; k++) begin
         drive_cycle(1'b0, 3'd0, 8'h00, 1'b1, om[k], 3'd3);
         total++;
         if (rb_data !== ev[k]) begin bad++; $display("FAIL incdec%0d_val got=%h exp=%h", k, rb_data, ev[k]); end
         total++;
         if (carry !== ec[k]) begin bad++; $display("FAIL incdec%0d_carry got=%b exp=%b", k, carry, ec[k]); end
         total++;
         if (zero_flags[3] !== (ev[k] == 8'h00)) begin
            bad++; $display("FAIL incdec%0d_zf3 got=%b exp=%b", k, zero_flags[3], ev[k] == 8'h00);
         end
      end
   endtask

   task automatic test_collision();
      // Carry is 0 entering here; a dropped op must not touch it.
      drive_cycle(1'b1, 3'd2, 8'h55, 1'b1, 2'b11, 3'd2);
      ra_addr = 3'd2; #1;
      total++;
      if (ra_data !== 8'h55) begin bad++; $display("FAIL coll_val got=%h exp=55", ra_data); end
      total++;
      if (op_conflict !== 1'b1) begin bad++; $display("FAIL coll_pulse got=%b exp=1", op_conflict); end
      total++;
      if (carry !== 1'b0) begin bad++; $display("FAIL coll_carry got=%b exp=0", carry); end
      tick();
      total++;
      if (op_conflict !== 1'b0) begin bad++; $display("FAIL coll_pulse_end got=%b exp=0", op_conflict); end
      drive_cycle(1'b1, 3'd5, 8'h10, 1'b0, 2'b00, 3'd0);
      drive_cycle(1'b1, 3'd2, 8'h55, 1'b1, 2'b01, 3'd5);
      ra_addr = 3'd2; rb_addr = 3'd5; #1;
      total++;
      if (ra_data !== 8'h55) begin bad++; $display("FAIL split_reg2 got=%h exp=55", ra_data); end
      total++;
      if (rb_data !== 8'h11) begin bad++; $display("FAIL split_reg5 got=%h exp=11", rb_data); end
      total++;
      if (op_conflict !== 1'b0) begin bad++; $display("FAIL split_conflict got=%b exp=0", op_conflict); end
   endtask

   task automatic test_read_only();
      // Set carry to 1 first so "unchanged" is distinguishable from a clear.
      drive_cycle(1'b1, 3'd6, 8'hFF, 1'b0, 2'b00, 3'd0);
      drive_cycle(1'b0, 3'd0, 8'h00, 1'b1, 2'b01, 3'd6);
      drive_cycle(1'b1, 3'd0, 8'h12, 1'b1, 2'b01, 3'd0);
      ra_addr = 3'd0; #1;
      total++;
      if (ra_data !== 8'h00) begin bad++; $display("FAIL ro_val got=%h exp=00", ra_data); end
      total++;
      if (carry !== 1'b1) begin bad++; $display("FAIL ro_carry got=%b exp=1", carry); end
      total++;
      if (op_conflict !== 1'b0) begin bad++; $display("FAIL ro_conflict got=%b exp=0", op_conflict); end
      total++;
      if (zero_flags[0] !== 1'b1) begin bad++; $display("FAIL ro_zf0 got=%b exp=1", zero_flags[0]); end
   endtask

   task automatic test_no_bypass();
      logic [DW-1:0] old_v;
      old_v = model[4];
      ra_addr = 3'd4;
      CS = 1'b1; RD_WR = 1'b0; address = 3'd4; oe = 1'b1; drv = 8'h77;
      #3;
      total++;
      if (ra_data !== old_v) begin bad++; $display("FAIL bypass_old got=%h exp=%h", ra_data, old_v); end
      tick();
      CS = 1'b0; oe = 1'b0; model[4] = 8'h77;
      total++;
      if (ra_data !== 8'h77) begin bad++; $display("FAIL bypass_new got=%h exp=77", ra_data); end
   endtask

   task automatic test_back_to_back();
      logic [DW-1:0] ev [3] = '{8'hFE, 8'hFF, 8'h00};
      logic          ec [3] = '{1'b0, 1'b0, 1'b1};
      drive_cycle(1'b1, 3'd1, 8'hFD, 1'b0, 2'b00, 3'd0);
      ra_addr = 3'd1;
      op_en = 1'b1; op_mode = 2'b01; op_addr = 3'd1;
      for (int k = 0; k < 3; k++) begin
         tick();
         total++;
         if (ra_data !== ev[k]) begin bad++; $display("FAIL b2b%0d_val got=%h exp=%h", k, ra_data, ev[k]); end
         total++;
         if (carry !== ec[k]) begin bad++; $display("FAIL b2b%0d_carry got=%b exp=%b", k, carry, ec[k]); end
      end
      // Reset mid-burst: concurrent write and op are discarded.
      reset = 1'b0; CS = 1'b1; RD_WR = 1'b0; address = 3'd5; oe = 1'b1; drv = 8'h99;
      tick();
      reset = 1'b1; CS = 1'b0; oe = 1'b0; op_en = 1'b0;
      rb_addr = 3'd5; #1;
      total++;
      if (ra_data !== 8'h00) begin bad++; $display("FAIL midrst_reg1 got=%h exp=00", ra_data); end
      total++;
      if (rb_data !== 8'h00) begin bad++; $display("FAIL midrst_reg5 got=%h exp=00", rb_data); end
      total++;
      if (zero_flags !== 8'hFF) begin bad++; $display("FAIL midrst_zf got=%h exp=ff", zero_flags); end
      total++;
      if (carry !== 1'b0) begin bad++; $display("FAIL midrst_carry got=%b exp=0", carry); end
   endtask

   initial begin
      reset = 1'b0; CS = 1'b0; RD_WR = 1'b0; address = '0; oe = 1'b0; drv = '0;
      ra_addr = '0; rb_addr = '0; op_en = 1'b0; op_mode = 2'b00; op_addr = '0;
      test_reset();
      test_write_read();
      test_inc_dec();
      test_collision();
      test_read_only();
      test_no_bypass();
      test_back_to_back();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
